// File: rtl/fifo_rd_ser.sv
// fifo_rd_ser: drains wide words from a first-word-fall-through FIFO read port
// and presents them as a narrower valid/ready stream, least-significant chunk
// first, at one chunk per cycle with no bubble between words.
//
// Integration note: fifo_ena depends combinationally on out_ready and
// fifo_empty, so it must not feed back into either of them through logic.
module fifo_rd_ser #(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  fifo_data,
  output logic                 fifo_ena,
  input  logic                 fifo_empty,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int unsigned RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int unsigned CW    = (RATIO > 1) ? $clog2(RATIO) : 1;

  typedef enum logic {StEmpty, StHold} state_e;

  state_e              state;
  logic [IN_WIDTH-1:0] word_reg;
  logic [CW-1:0]       cnt;
  logic                hold;
  logic                take;

  assign hold = (state == StHold);

  // Outputs depend only on registered state, never on out_ready.
  always_comb begin
    out_data  = word_reg[32'(cnt) * OUT_WIDTH +: OUT_WIDTH];
    out_last  = (32'(cnt) == RATIO - 1);
    out_valid = hold;
    busy      = hold;
  end

  // Pop a new word when idle, or when the final chunk of the held word leaves
  // this cycle; this is what removes the inter-word bubble.
  always_comb begin
    take     = ~hold | (out_ready & out_last);
    fifo_ena = take & ~fifo_empty & ~rst;
  end

  // Hold/empty state machine with chunk counter and word register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StEmpty;
      cnt      <= '0;
      word_reg <= '0;
    end else if (fifo_ena) begin
      word_reg <= fifo_data;
      cnt      <= '0;
      state    <= StHold;
    end else if (hold && out_ready) begin
      if (!out_last) begin
        cnt <= cnt + 1'b1;
      end else begin
        // Final chunk gone and nothing to refill with.
        state <= StEmpty;
        cnt   <= '0;
      end
    end
  end

endmodule
